fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Shares the single write port of the team's FIFO between NUM_REQ independent requesters.
- Each requester uses a valid/ready handshake. The block drives the FIFO write enable and data, and respects the FIFO full flag.
- Round-robin arbitration with bounded bursts: a requester keeps the port for up to MAX_BURST beats, then the grant rotates.
- Sits directly in front of the FIFO write side; CLK is the FIFO write clock.

Parameters:
- DATA_WIDTH, 8: width of one data beat.
- NUM_REQ, 4: number of requesters, >= 2.
- MAX_BURST, 4: maximum beats per grant, >= 1.

Ports:
- CLK  in  1  single clock; also clocks the FIFO write side.
- RST_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester data valid.
- req_data  in  NUM_REQ*DATA_WIDTH  flattened data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_data_in  out  DATA_WIDTH  FIFO write data.
- grant_valid  out  1  a burst grant is active.
- grant_id  out  $clog2(NUM_REQ)  index of the granted requester.

Behaviour:
- Reset (RST_n low, asynchronous):
  - state=IDLE, grant_valid=0, grant_id=0, rr_ptr=0, beat_cnt=0.
  - fifo_wr_en=0, req_ready=0, fifo_data_in=0.
- Registered state: state (IDLE/BURST), grant_id, rr_ptr, beat_cnt (width $clog2(MAX_BURST+1)).
- IDLE:
  - If any req_valid is high, select the first asserted index scanning upward from rr_ptr, wrapping NUM_REQ-1 -> 0.
  - Register it into grant_id, clear beat_cnt and go to BURST.
  - No transfer occurs in IDLE; arbitration latency is 1 cycle.
- BURST outputs (combinational from registered grant):
  - xfer = req_valid[grant_id] & ~fifo_full.
  - fifo_wr_en = xfer.
  - req_ready[grant_id] = xfer; all other ready bits are 0.
  - fifo_data_in = req_data[grant_id] when grant_valid, else 0.
  - grant_valid=1.
- Beat counting: beat_cnt increments on each xfer only. A fifo_full stall holds beat_cnt and the grant.
- Release, then next state IDLE with rr_ptr = grant_id+1 mod NUM_REQ:
  - xfer with beat_cnt == MAX_BURST-1 (burst complete), or
  - req_valid[grant_id]==0 in BURST (requester done).
- Full plus valid: no release, no transfer; wait indefinitely.
- The full flag is observed on the same edge as the write, so no write is ever issued while full is high.
- Every release costs exactly one IDLE cycle before the next grant; no back-to-back grant chaining.
- Requester contract: a requester must hold req_data stable while req_valid is high and req_ready is low. The block does not check this.
- Reset mid-burst: any beat not yet accepted is discarded. After reset, requester 0 has highest priority.
- MAX_BURST=1: release after every beat, giving strict per-beat round-robin.

Decomposition:
- Shared header/package:
  - state encodings ST_IDLE=1'b0, ST_BURST=1'b1.
  - localparams REQ_IDX_W=$clog2(NUM_REQ) and CNT_W=$clog2(MAX_BURST+1).
- One sub-module, rr_priority_picker (combinational):
  - inputs: request vector, rr_ptr.
  - outputs: any_req, chosen index.
  - implemented by a doubled-vector mask scan.
- FSM, counter and data mux stay in fifo_write_arbiter.

Test Plan (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4):
1. RST_n=0 with all req_valid=1 -> fifo_wr_en=0, req_ready=0, grant_valid=0, grant_id=0 immediately. After RST_n=1 the first grant goes to requester 0.
2. Only req 1 valid for 6 beats, data 0xA0..0xA5, fifo_full=0:
   - idle cycle, then grant_id=1 and writes A0,A1,A2,A3;
   - one IDLE cycle, then regrant 1 and writes A4,A5;
   - release on valid drop. FIFO receives A0..A5 in order.
3. All 4 requesters continuously valid -> grant_id sequence 0,1,2,3,0. Each grant has 4 writes, with exactly one idle cycle between grants.
4. Req 2 granted; fifo_full=1 for 3 cycles after beat 2 -> fifo_wr_en=0 and req_ready=0 for those cycles, beat_cnt held at 2. The burst then resumes, totals 4 beats, and data order is preserved.
5. Req 2 drops valid after 2 beats while req 3 and req 0 are valid -> release; next grant_id=3 (rr_ptr=3), not 0.
6. RST_n pulsed low mid-burst to req 3 -> outputs zero asynchronously. After release, with reqs 0 and 3 valid, grant_id=0.

Source files
------------

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
// Imported by fifo_write_arbiter; holds state encodings and widths.
package fifo_write_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_MAX_BURST  = 4;

  localparam int REQ_IDX_W = $clog2(DEF_NUM_REQ);
  localparam int CNT_W     = $clog2(DEF_MAX_BURST + 1);

endpackage

// File: rtl/fifo_write_arbiter_rr_priority_picker.sv
// Round-robin picker: first set request at or above ptr, wrapping.
// Ports: req (vector), ptr (start index) -> any_req, idx (chosen).
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any_req,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             off;
  int             sum;

  // Rotate by ptr via the doubled vector, take the lowest set bit,
  // then map the offset back to an absolute index.
  always_comb begin
    dbl = {req, req};
    rot = dbl[ptr +: N];
    off = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) off = j;
    end
    sum = int'(ptr) + off;
    if (sum >= N) sum = sum - N;
    idx     = IW'(sum);
    any_req = |req;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded sharing of one FIFO write port.
// Ports: CLK, RST_n, req_valid/req_data/req_ready, fifo_full,
//        fifo_wr_en, fifo_data_in, grant_valid, grant_id.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                          CLK,
  input  logic                          RST_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  state_t        state, state_n;
  logic [IW-1:0] grant_n;
  logic [IW-1:0] rr_ptr, rr_ptr_n;
  logic [CW-1:0] beat_cnt, beat_cnt_n;
  logic          any_req;
  logic [IW-1:0] pick;
  logic          xfer;
  logic [IW-1:0] gid_inc;

  rr_priority_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .any_req (any_req),
    .idx     (pick)
  );

  assign xfer = (state == ST_BURST)
              & req_valid[grant_id]
              & ~fifo_full;

  assign gid_inc = (grant_id == IW'(NUM_REQ - 1))
                 ? '0 : grant_id + 1'b1;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state    <= ST_IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      grant_id <= grant_n;
      rr_ptr   <= rr_ptr_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  // A stall on full keeps everything; a dropped valid or the last
  // beat releases, always passing through one IDLE cycle.
  always_comb begin
    state_n    = state;
    grant_n    = grant_id;
    rr_ptr_n   = rr_ptr;
    beat_cnt_n = beat_cnt;
    unique case (state)
      ST_IDLE: begin
        if (any_req) begin
          grant_n    = pick;
          beat_cnt_n = '0;
          state_n    = ST_BURST;
        end
      end
      ST_BURST: begin
        if (xfer) beat_cnt_n = beat_cnt + 1'b1;
        if (!req_valid[grant_id] ||
            (xfer && beat_cnt == CW'(MAX_BURST - 1))) begin
          state_n  = ST_IDLE;
          rr_ptr_n = gid_inc;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_valid = (state == ST_BURST);
    fifo_wr_en  = xfer;
    req_ready   = '0;
    if (xfer) req_ready[grant_id] = 1'b1;
    fifo_data_in = '0;
    if (grant_valid)
      fifo_data_in = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with per-cycle expected rows.
// Small requester model supplies data; rows hold hand-derived outputs.
module tb_fifo_write_arbiter;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data_in;
  logic        grant_valid;
  logic [1:0]  grant_id;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  fifo_write_arbiter #(
    .DATA_WIDTH (8),
    .NUM_REQ    (4),
    .MAX_BURST  (4)
  ) dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id)
  );

  typedef struct {
    logic       gv;
    logic [1:0] gid;
    logic       wr;
    logic [7:0] dat;
    logic       full;
    logic [3:0] en;
    int         cnt;
  } row_t;

  row_t tr[$];
  int   taken[4];
  int   lim[4];
  int   base[4];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic add(input logic gv, input logic [1:0] gid,
                     input logic wr, input logic [7:0] dat,
                     input logic full, input logic [3:0] en,
                     input int cnt);
    row_t r;
    r.gv = gv; r.gid = gid; r.wr = wr; r.dat = dat;
    r.full = full; r.en = en; r.cnt = cnt;
    tr.push_back(r);
  endtask

  task automatic drive(input logic [3:0] en);
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = en[i] && (taken[i] < lim[i]);
      req_data[i*8 +: 8] = 8'(base[i] + taken[i]);
    end
  endtask

  task automatic run(input string tag);
    for (int k = 0; k < tr.size(); k++) begin
      row_t r;
      r = tr[k];
      fifo_full = r.full;
      drive(r.en);
      @(negedge CLK);
      chk({tag, ".gv"}, 32'(grant_valid), 32'(r.gv));
      chk({tag, ".wr"}, 32'(fifo_wr_en), 32'(r.wr));
      chk({tag, ".rdy"}, 32'(req_ready),
          r.wr ? (32'd1 << r.gid) : 32'd0);
      if (r.gv) chk({tag, ".gid"}, 32'(grant_id), 32'(r.gid));
      if (r.wr || !r.gv)
        chk({tag, ".dat"}, 32'(fifo_data_in), 32'(r.dat));
      if (r.cnt >= 0)
        chk({tag, ".cnt"}, 32'(dut.beat_cnt), 32'(r.cnt));
      if (r.wr) taken[r.gid]++;
      @(posedge CLK);
      #1;
    end
    tr.delete();
  endtask

  task automatic do_reset();
    RST_n     = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      taken[i] = 0;
      lim[i]   = 0;
    end
    @(posedge CLK);
    #1;
    RST_n = 1'b1;
  endtask

  initial begin
    base[0] = 'h10; base[1] = 'hA0;
    base[2] = 'hC0; base[3] = 'hD0;
    for (int i = 0; i < 4; i++) begin
      taken[i] = 0;
      lim[i]   = 100;
    end
    RST_n     = 1'b0;
    fifo_full = 1'b0;
    drive(4'hF);
    #2;
    chk("t1.rst_wr", 32'(fifo_wr_en), 0);
    chk("t1.rst_rdy", 32'(req_ready), 0);
    chk("t1.rst_gv", 32'(grant_valid), 0);
    chk("t1.rst_gid", 32'(grant_id), 0);
    chk("t1.rst_dat", 32'(fifo_data_in), 0);
    @(posedge CLK);
    #1;
    RST_n = 1'b1;
    add(0, 0, 0, 8'h00, 0, 4'hF, -1);
    add(1, 0, 1, 8'h10, 0, 4'hF, 0);
    run("t1");

    // single requester, 6 beats, split 4 + 2
    do_reset();
    lim[1] = 6;
    add(0, 0, 0, 8'h00, 0, 4'h2, -1);
    add(1, 1, 1, 8'hA0, 0, 4'h2, 0);
    add(1, 1, 1, 8'hA1, 0, 4'h2, 1);
    add(1, 1, 1, 8'hA2, 0, 4'h2, 2);
    add(1, 1, 1, 8'hA3, 0, 4'h2, 3);
    add(0, 1, 0, 8'h00, 0, 4'h2, -1);
    add(1, 1, 1, 8'hA4, 0, 4'h2, 0);
    add(1, 1, 1, 8'hA5, 0, 4'h2, 1);
    add(1, 1, 0, 8'h00, 0, 4'h2, 2);
    add(0, 1, 0, 8'h00, 0, 4'h2, -1);
    run("t2");

    // all requesters busy: rotation 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 4; i++) lim[i] = 100;
    add(0, 0, 0, 8'h00, 0, 4'hF, -1);
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < 4; b++)
        add(1, 2'(g), 1, 8'(base[g] + b), 0, 4'hF, b);
      add(0, 0, 0, 8'h00, 0, 4'hF, -1);
    end
    add(1, 0, 1, 8'h14, 0, 4'hF, 0);
    run("t3");

    // full stall after two beats
    do_reset();
    lim[2] = 4;
    add(0, 0, 0, 8'h00, 0, 4'h4, -1);
    add(1, 2, 1, 8'hC0, 0, 4'h4, 0);
    add(1, 2, 1, 8'hC1, 0, 4'h4, 1);
    add(1, 2, 0, 8'h00, 1, 4'h4, 2);
    add(1, 2, 0, 8'h00, 1, 4'h4, 2);
    add(1, 2, 0, 8'h00, 1, 4'h4, 2);
    add(1, 2, 1, 8'hC2, 0, 4'h4, 2);
    add(1, 2, 1, 8'hC3, 0, 4'h4, 3);
    add(0, 2, 0, 8'h00, 0, 4'h4, -1);
    add(0, 2, 0, 8'h00, 0, 4'h4, -1);
    run("t4");

    // early release of req 2 hands off to req 3, not req 0
    do_reset();
    lim[0] = 100; lim[2] = 2; lim[3] = 100;
    add(0, 0, 0, 8'h00, 0, 4'h4, -1);
    add(1, 2, 1, 8'hC0, 0, 4'hD, 0);
    add(1, 2, 1, 8'hC1, 0, 4'hD, 1);
    add(1, 2, 0, 8'h00, 0, 4'hD, 2);
    add(0, 2, 0, 8'h00, 0, 4'hD, -1);
    add(1, 3, 1, 8'hD0, 0, 4'hD, 0);
    run("t5");

    // async reset mid-burst to req 3
    do_reset();
    lim[0] = 100; lim[3] = 100;
    add(0, 0, 0, 8'h00, 0, 4'h8, -1);
    add(1, 3, 1, 8'hD0, 0, 4'h8, 0);
    add(1, 3, 1, 8'hD1, 0, 4'h8, 1);
    run("t6a");
    drive(4'h9);
    #2;
    RST_n = 1'b0;
    #1;
    chk("t6.rst_wr", 32'(fifo_wr_en), 0);
    chk("t6.rst_rdy", 32'(req_ready), 0);
    chk("t6.rst_gv", 32'(grant_valid), 0);
    chk("t6.rst_gid", 32'(grant_id), 0);
    chk("t6.rst_dat", 32'(fifo_data_in), 0);
    @(posedge CLK);
    #1;
    RST_n = 1'b1;
    add(0, 0, 0, 8'h00, 0, 4'h9, -1);
    add(1, 0, 1, 8'h10, 0, 4'h9, 0);
    run("t6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
